nios2_mul_seq: RTL and testbench
================================

# nios2_mul_seq

Multi-cycle multiply sequencer for the Nios II execute path. It accepts a 32x32 multiply request over a valid/ready handshake and drives operands into the 16x16 partial-product multiplier cell. It collects the cell's three partial products (lo·lo, lo·hi, hi·lo) and combines them into the low result word. Optionally it runs a second cell pass (hi·hi) to produce the high word for MULXUU/MULXSU/MULXSS.

## Interface
Parameters:
- CELL_LATENCY, 1: cycles from the first cell_en until cell_p* are valid. Must match the cell's pipeline depth; range 1..4.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high. Resets all state and outputs.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; forced 0 while reset is high.
- req_op  in  2  00 MUL, 01 MULXUU, 10 MULXSU (src1 signed, src2 unsigned), 11 MULXSS.
- req_src1, req_src2  in  32  operands A and B.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_result  out  32  low word for MUL, high word otherwise.
- cell_src1, cell_src2  out  32  operands driven to the cell. Registered.
- cell_en  out  1  cell pipeline enable.
- cell_p1, cell_p2, cell_p3  in  32  cell partial products: a_lo·b_lo, a_lo·b_hi, a_hi·b_lo (unsigned).

## Operation
- States: IDLE, ISSUE1, CAP1, ISSUE2, CAP2, DONE. Reset state is IDLE.
- IDLE: req_ready=1. On req_valid&req_ready:
  - latch A, B and op;
  - load cell_src1=A, cell_src2=B;
  - go to ISSUE1.
- ISSUE1: cell_en=1 for CELL_LATENCY cycles (down-counter). Operands are held stable. Then go to CAP1.
- CAP1 samples cell_p1..p3:
  - mid = p2+p3, 33 bits;
  - s = p1 + {mid[15:0],16'b0}, 33 bits;
  - lo = s[31:0];
  - carry = s[32].
  - Register lo, mid[32:16] and carry.
  - If op==MUL, result=lo and go to DONE.
  - Otherwise load cell_src1={16'b0,A[31:16]}, cell_src2={16'b0,B[31:16]} and go to ISSUE2.
- ISSUE2: same as ISSUE1, then go to CAP2.
- CAP2 computes hu = cell_p1 + mid[32:16] + carry, mod 2^32, then applies the op:
  - MULXUU: result=hu;
  - MULXSU: result = hu − (A[31]?B:0);
  - MULXSS: result = hu − (A[31]?B:0) − (B[31]?A:0).
  - All arithmetic is mod 2^32. Then go to DONE.
- DONE: rsp_valid=1 and rsp_result is held. On rsp_ready, go to IDLE.
- cell_en=0 in every state except ISSUE1/ISSUE2.
- Reset mid-operation: state returns to IDLE immediately and no response is emitted. The in-flight request is dropped.
- Reset values: req_ready=0 (during reset), rsp_valid=0, rsp_result=0, cell_src1=0, cell_src2=0, cell_en=0.

## Timing
- Accept edge is the end of cycle 0.
- Cycles 1..L are ISSUE1, where L=CELL_LATENCY; cycle L+1 is CAP1.
- MUL: rsp_valid first high in cycle L+2 (3 cycles for L=1).
- High ops: ISSUE2 is cycles L+2..2L+1, CAP2 is cycle 2L+2, rsp_valid first high in cycle 2L+3 (5 cycles for L=1).
- The response handshake takes one cycle. The next request is accepted no earlier than the cycle after the rsp handshake, so there is no overlap.
- rsp_valid with rsp_ready low: rsp_valid and rsp_result stay stable indefinitely.
- req_valid while busy is ignored (req_ready=0). The requester must hold its request.

## Configuration
- NIOS2_MUL_SEQ_HIGH_EN defined: full behaviour above, all four ops.
- Not defined:
  - ISSUE2/CAP2, the mid/carry high-word registers and the sign correction are removed;
  - req_op is ignored and every op returns the low word through the MUL path (latency L+2).

## Structure
- Package nios2_mul_pkg holds:
  - typedef mul_op_t, the 2-bit op enum;
  - typedef mul_state_t;
  - constant MUL_CELL_LATENCY_DEFAULT=1.
- One sub-module, nios2_mul_combine: combinational. Inputs p1..p3; outputs lo, mid_hi[16:0], carry. Instantiated once and used in CAP1.

## Test plan
- MUL A=0x0001_0002, B=0x0003_0004 (cell model p1=8, p2=6, p3=4) -> rsp_result 0x000A_0008, rsp_valid in cycle 3 (L=1).
- MUL and MULXUU with A=B=0xFFFF_FFFF -> 0x0000_0001 (cycle 3) and 0xFFFF_FFFE (cycle 5). Exactly 2 cell_en pulses for MULXUU.
- MULXSU A=B=0xFFFF_FFFF -> 0xFFFF_FFFF. MULXSS A=B=0xFFFF_FFFF -> 0x0000_0000. MULXSS A=0x8000_0000, B=2 -> 0xFFFF_FFFF.
- Backpressure: rsp_ready low for 10 cycles with result 0x000A_0008 -> rsp_valid and result stable, req_ready=0, cell_en=0. A second request held on req_valid is accepted the cycle after the rsp handshake.
- Reset pulse during ISSUE2 -> all outputs 0 the same cycle and no response. After release, MUL 7×6 -> 0x0000_002A.
- Macro undefined: MULXUU A=B=0xFFFF_FFFF -> 0x0000_0001 in cycle 3, single cell_en pulse.

Source files
------------

// File: rtl/nios2_mul_pkg.sv
// nios2_mul_pkg: shared types and constants for the Nios II multiply sequencer.
package nios2_mul_pkg;

    localparam int MUL_CELL_LATENCY_DEFAULT = 1;

    typedef enum logic [1:0] {
        MUL_OP_MUL = 2'b00,
        MUL_OP_XUU = 2'b01,
        MUL_OP_XSU = 2'b10,
        MUL_OP_XSS = 2'b11
    } mul_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE1,
        ST_CAP1,
        ST_ISSUE2,
        ST_CAP2,
        ST_DONE
    } mul_state_t;

endpackage

// File: rtl/nios2_mul_combine.sv
// nios2_mul_combine: folds the lo*lo, lo*hi and hi*lo partial products into the low word plus high-word carries.
module nios2_mul_combine
    import nios2_mul_pkg::*;
(
    input  logic [31:0] p1,
    input  logic [31:0] p2,
    input  logic [31:0] p3,
    output logic [31:0] lo,
    output logic [16:0] mid_hi,
    output logic        carry
);
    logic [32:0] mid;
    logic [32:0] s;

    // Cross terms share bit weight 2^16; only their low half lands in the low word.
    always_comb begin
        mid    = {1'b0, p2} + {1'b0, p3};
        s      = {1'b0, p1} + {1'b0, mid[15:0], 16'b0};
        lo     = s[31:0];
        carry  = s[32];
        mid_hi = mid[32:16];
    end

endmodule

// File: rtl/nios2_mul_seq.sv
// nios2_mul_seq: multi-cycle 32x32 multiply sequencer over a 16x16 partial-product cell; NIOS2_MUL_SEQ_HIGH_EN enables the high-word ops.
module nios2_mul_seq
    import nios2_mul_pkg::*;
#(
    parameter int CELL_LATENCY = MUL_CELL_LATENCY_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [31:0] cell_src1,
    output logic [31:0] cell_src2,
    output logic        cell_en,
    input  logic [31:0] cell_p1,
    input  logic [31:0] cell_p2,
    input  logic [31:0] cell_p3
);
    localparam logic [1:0] CNT_INIT = 2'(CELL_LATENCY - 1);

    mul_state_t  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] cell_src1_q, cell_src1_d, cell_src2_q, cell_src2_d;
    logic [31:0] result_q, result_d;
    logic [31:0] lo;
    logic [16:0] mid_hi;
    logic        carry;

    nios2_mul_combine u_combine (
        .p1(cell_p1),
        .p2(cell_p2),
        .p3(cell_p3),
        .lo(lo),
        .mid_hi(mid_hi),
        .carry(carry)
    );

`ifdef NIOS2_MUL_SEQ_HIGH_EN
    mul_op_t     op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [16:0] mid_hi_q, mid_hi_d;
    logic        carry_q, carry_d;
    logic [31:0] hu, corr_a, corr_b;

    assign hu     = cell_p1 + 32'(mid_hi_q) + 32'(carry_q);
    assign corr_a = (a_q[31] && (op_q == MUL_OP_XSU || op_q == MUL_OP_XSS)) ? b_q : '0;
    assign corr_b = (b_q[31] && op_q == MUL_OP_XSS) ? a_q : '0;

    // Operand, op and first-pass carry state kept for the hi*hi pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= MUL_OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            mid_hi_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mid_hi_q <= mid_hi_d;
            carry_q  <= carry_d;
        end
    end
`else
    logic unused_high;
    assign unused_high = ^{req_op, mid_hi, carry};
`endif

    // Next-state, cell operand and result selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cell_src1_d = cell_src1_q;
        cell_src2_d = cell_src2_q;
        result_d    = result_q;
`ifdef NIOS2_MUL_SEQ_HIGH_EN
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        mid_hi_d    = mid_hi_q;
        carry_d     = carry_q;
`endif
        unique case (state_q)
            ST_IDLE: if (req_valid) begin
                cell_src1_d = req_src1;
                cell_src2_d = req_src2;
                cnt_d       = CNT_INIT;
                state_d     = ST_ISSUE1;
`ifdef NIOS2_MUL_SEQ_HIGH_EN
                op_d        = mul_op_t'(req_op);
                a_d         = req_src1;
                b_d         = req_src2;
`endif
            end
            ST_ISSUE1: begin
                cnt_d   = cnt_q - 2'd1;
                state_d = (cnt_q == 2'd0) ? ST_CAP1 : ST_ISSUE1;
            end
            ST_CAP1: begin
`ifdef NIOS2_MUL_SEQ_HIGH_EN
                mid_hi_d = mid_hi;
                carry_d  = carry;
                if (op_q == MUL_OP_MUL) begin
                    result_d = lo;
                    state_d  = ST_DONE;
                end else begin
                    cell_src1_d = {16'b0, a_q[31:16]};
                    cell_src2_d = {16'b0, b_q[31:16]};
                    cnt_d       = CNT_INIT;
                    state_d     = ST_ISSUE2;
                end
`else
                result_d = lo;
                state_d  = ST_DONE;
`endif
            end
`ifdef NIOS2_MUL_SEQ_HIGH_EN
            ST_ISSUE2: begin
                cnt_d   = cnt_q - 2'd1;
                state_d = (cnt_q == 2'd0) ? ST_CAP2 : ST_ISSUE2;
            end
            ST_CAP2: begin
                result_d = hu - corr_a - corr_b;
                state_d  = ST_DONE;
            end
`endif
            ST_DONE: state_d = rsp_ready ? ST_IDLE : ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state and registered outputs; reset drops any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cell_src1_q <= '0;
            cell_src2_q <= '0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cell_src1_q <= cell_src1_d;
            cell_src2_q <= cell_src2_d;
            result_q    <= result_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE) && !reset;
    assign rsp_valid  = state_q == ST_DONE;
    assign rsp_result = result_q;
    assign cell_src1  = cell_src1_q;
    assign cell_src2  = cell_src2_q;
    assign cell_en    = (state_q == ST_ISSUE1) || (state_q == ST_ISSUE2);

endmodule

// File: tb/tb_nios2_mul_seq.sv
// tb_nios2_mul_seq: self-checking bench for nios2_mul_seq with a pipelined cell model and an arithmetic reference.
module tb_nios2_mul_seq;
    localparam int L = 1;
`ifdef NIOS2_MUL_SEQ_HIGH_EN
    localparam bit HIGH = 1'b1;
`else
    localparam bit HIGH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'b00;
    logic [31:0] req_src1 = '0;
    logic [31:0] req_src2 = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [31:0] cell_src1, cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1, cell_p2, cell_p3;
    int total = 0;
    int bad = 0;

    nios2_mul_seq #(.CELL_LATENCY(L)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_src1(req_src1),
        .req_src2(req_src2),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .cell_src1(cell_src1),
        .cell_src2(cell_src2),
        .cell_en(cell_en),
        .cell_p1(cell_p1),
        .cell_p2(cell_p2),
        .cell_p3(cell_p3)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mul16(input logic [15:0] x, input logic [15:0] y);
        return 32'(x) * 32'(y);
    endfunction

    logic [95:0] pipe [L];
    always @(posedge clk) if (cell_en) begin
        pipe[0] <= {mul16(cell_src1[15:0], cell_src2[15:0]),
                    mul16(cell_src1[15:0], cell_src2[31:16]),
                    mul16(cell_src1[31:16], cell_src2[15:0])};
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
    assign cell_p1 = pipe[L-1][95:64];
    assign cell_p2 = pipe[L-1][63:32];
    assign cell_p3 = pipe[L-1][31:0];

    function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub, sa, sb, p;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        if (!HIGH || op == 2'b00) return 32'(ua * ub);
        p = (op == 2'b01) ? ua * ub : (op == 2'b10) ? sa * ub : sa * sb;
        return p[63:32];
    endfunction

    function automatic int model_lat(input logic [1:0] op);
        return (HIGH && op != 2'b00) ? 2 * L + 3 : L + 2;
    endfunction

    function automatic int model_ens(input logic [1:0] op);
        return (HIGH && op != 2'b00) ? 2 * L : L;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int ens);
        int g;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = op;
        req_src1 = a;
        req_src2 = b;
        g = 0;
        while (!req_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = -1;
        ens = 0;
        for (int c = 1; c <= 50; c++) begin
            ens += int'(cell_en);
            if (rsp_valid) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        res = rsp_result;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        total += 5;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
        if (cell_en !== 1'b0) begin bad++; $display("FAIL rst_cell_en got=%b exp=0", cell_en); end
        if ({cell_src1, cell_src2} !== 64'h0) begin bad++; $display("FAIL rst_cell_src got=%h_%h exp=0", cell_src1, cell_src2); end
        if (rsp_result !== 32'h0) begin bad++; $display("FAIL rst_result got=%h exp=0", rsp_result); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL idle_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_directed();
        logic [1:0]  ops  [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
        logic [31:0] as   [6] = '{32'h0001_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [31:0] bs   [6] = '{32'h0003_0004, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002};
        logic [31:0] exph [6] = '{32'h000A_0008, 32'h1, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
        logic [31:0] expl [6] = '{32'h000A_0008, 32'h1, 32'h1, 32'h1, 32'h1, 32'h0};
        logic [31:0] res, exp_res;
        int lat, ens;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat, ens);
            exp_res = HIGH ? exph[i] : expl[i];
            total += 3;
            if (res !== exp_res) begin bad++; $display("FAIL dir%0d_result got=%h exp=%h", i, res, exp_res); end
            if (lat != model_lat(ops[i])) begin bad++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, model_lat(ops[i])); end
            if (ens != model_ens(ops[i])) begin bad++; $display("FAIL dir%0d_cell_en got=%0d exp=%0d", i, ens, model_ens(ops[i])); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a, b, res;
        int lat, ens;
        for (int i = 0; i < 40; i++) begin
            op = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if (i % 8 == 0) a = {1'b1, 31'($urandom_range(0, 3))};
            if (i % 8 == 4) b = 32'hFFFF_0000 | 32'($urandom_range(0, 65535));
            run_op(op, a, b, res, lat, ens);
            total += 2;
            if (res !== model(op, a, b)) begin bad++; $display("FAIL rnd%0d op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, res, model(op, a, b)); end
            if (lat != model_lat(op)) begin bad++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, model_lat(op)); end
        end
    endtask

    task automatic test_backpressure();
        int c;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 2'b00;
        req_src1 = 32'h0001_0002;
        req_src2 = 32'h0003_0004;
        @(negedge clk);
        c = 0;
        while (!rsp_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        req_src1 = 32'd7;
        req_src2 = 32'd6;
        for (int i = 0; i < 10; i++) begin
            total += 4;
            if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp%0d_rsp_valid got=%b exp=1", i, rsp_valid); end
            if (rsp_result !== 32'h000A_0008) begin bad++; $display("FAIL bp%0d_result got=%h exp=000a0008", i, rsp_result); end
            if (req_ready !== 1'b0) begin bad++; $display("FAIL bp%0d_req_ready got=%b exp=0", i, req_ready); end
            if (cell_en !== 1'b0) begin bad++; $display("FAIL bp%0d_cell_en got=%b exp=0", i, cell_en); end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        total += 2;
        if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_after_hs_req_ready got=%b exp=1", req_ready); end
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_after_hs_rsp_valid got=%b exp=0", rsp_valid); end
        @(negedge clk);
        req_valid = 1'b0;
        total += 2;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_second_accept_req_ready got=%b exp=0", req_ready); end
        if (cell_en !== 1'b1) begin bad++; $display("FAIL bp_second_accept_cell_en got=%b exp=1", cell_en); end
        c = 0;
        while (!rsp_valid && c < 50) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (rsp_result !== 32'h0000_002A || !rsp_valid) begin bad++; $display("FAIL bp_second_result got=%h valid=%b exp=0000002a", rsp_result, rsp_valid); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int lat, ens;
        @(negedge clk);
        req_valid = 1'b1;
        req_op = 2'b01;
        req_src1 = 32'hFFFF_FFFF;
        req_src2 = 32'hFFFF_FFFF;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (L + 1) @(negedge clk);
        if (HIGH) begin
            total++;
            if (cell_en !== 1'b1) begin bad++; $display("FAIL mid_issue2_cell_en got=%b exp=1", cell_en); end
        end
        #1 reset = 1'b1;
        #1;
        total += 5;
        if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_req_ready got=%b exp=0", req_ready); end
        if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_rsp_valid got=%b exp=0", rsp_valid); end
        if (cell_en !== 1'b0) begin bad++; $display("FAIL mid_rst_cell_en got=%b exp=0", cell_en); end
        if ({cell_src1, cell_src2} !== 64'h0) begin bad++; $display("FAIL mid_rst_cell_src got=%h_%h exp=0", cell_src1, cell_src2); end
        if (rsp_result !== 32'h0) begin bad++; $display("FAIL mid_rst_result got=%h exp=0", rsp_result); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_post_rsp_valid%0d got=%b exp=0", i, rsp_valid); end
            @(negedge clk);
        end
        run_op(2'b00, 32'd7, 32'd6, res, lat, ens);
        total += 2;
        if (res !== 32'h0000_002A) begin bad++; $display("FAIL mid_post_mul got=%h exp=0000002a", res); end
        if (lat != L + 2) begin bad++; $display("FAIL mid_post_latency got=%0d exp=%0d", lat, L + 2); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
